// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / serializer handshake bundle used by uart_tx_arbiter.
// master = the arbiter, slave = the producers plus the UART shifter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_byte;
    logic                 tx_busy;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_active;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_byte, grant_id, grant_active
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_byte, grant_id, grant_active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-limited sharing of one UART transmitter among NUM_REQ byte sources.
// Optional feature: define UART_ARB_TAG_EN to send an 8'hA0|id tag byte at the start of every grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4,
    parameter int ID_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
`ifdef UART_ARB_TAG_EN
    localparam logic [2:0] ST_TAG       = 3'd5;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             grant_active_q, grant_active_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
`ifdef UART_ARB_TAG_EN
    logic             tag_phase_q, tag_phase_d;
`endif

    logic [NUM_REQ-1:0] req_ready_s;
    logic [7:0]         req_bytes_s [NUM_REQ];
    logic [ID_W-1:0]    pick_s;
    logic               pick_vld_s;
    logic               grant_vld_s;
    logic               tag_done_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    // First valid requester after ptr, wrapping; the descending loop leaves the closest one.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            res = vld[idx] ? {1'b1, ID_W'(idx)} : res;
        end
        return res;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes_s[i] = bus.req_data[8*i +: 8];
    end

    assign grant_vld_s = bus.req_valid[grant_id_q];
    assign cnt_inc_s   = burst_cnt_q + 1'b1;
`ifdef UART_ARB_TAG_EN
    assign tag_done_s  = tag_phase_q;
`else
    assign tag_done_s  = 1'b0;
`endif

    // Round-robin candidate for the next grant
    always_comb begin
        {pick_vld_s, pick_s} = rr_pick(bus.req_valid, rr_ptr_q);
    end

    // Grant / serializer sequencing
    always_comb begin
        state_d        = state_q;
        burst_cnt_d    = burst_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        tx_start_d     = 1'b0;
        tx_byte_d      = tx_byte_q;
`ifdef UART_ARB_TAG_EN
        tag_phase_d    = tag_phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    grant_id_d     = pick_s;
                    burst_cnt_d    = '0;
                    grant_active_d = 1'b1;
`ifdef UART_ARB_TAG_EN
                    state_d        = ST_TAG;
`else
                    state_d        = ST_LOAD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                tx_byte_d   = 8'hA0 | {{(8-ID_W){1'b0}}, grant_id_q};
                tag_phase_d = 1'b1;
                tx_start_d  = 1'b1;
                state_d     = ST_START;
            end
`endif
            ST_LOAD: begin
                // A source that dropped valid mid-handshake forfeits the grant
                if (grant_vld_s) begin
                    tx_byte_d  = req_bytes_s[grant_id_q];
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end else begin
                    grant_active_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tag_done_s) begin
`ifdef UART_ARB_TAG_EN
                    tag_phase_d = 1'b0;
`endif
                    state_d = ST_LOAD;
                end else begin
                    burst_cnt_d = cnt_inc_s;
                    if (grant_vld_s && (cnt_inc_s < CNT_W'(BURST_MAX))) begin
                        state_d = ST_LOAD;
                    end else begin
                        rr_ptr_d       = grant_id_q;
                        grant_active_d = 1'b0;
                        state_d        = ST_IDLE;
                    end
                end
            end
            default: begin
                grant_active_d = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            burst_cnt_q    <= '0;
            rr_ptr_q       <= ID_W'(NUM_REQ - 1);
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_byte_q      <= 8'h00;
`ifdef UART_ARB_TAG_EN
            tag_phase_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            burst_cnt_q    <= burst_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            tx_start_q     <= tx_start_d;
            tx_byte_q      <= tx_byte_d;
`ifdef UART_ARB_TAG_EN
            tag_phase_q    <= tag_phase_d;
`endif
        end
    end

    // Ready must follow a late valid drop and stay quiet while reset is asserted
    always_comb begin
        req_ready_s = '0;
        if (!rst && (state_q == ST_LOAD) && grant_vld_s) begin
            req_ready_s[grant_id_q] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign bus.req_ready    = req_ready_s;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_byte      = tx_byte_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.grant_active = grant_active_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue sources, a serializer model and a transaction-level
// round-robin/burst predictor checked every cycle, plus literal expectations for directed cases.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int BURST_MAX = 4;
    localparam int ID_W      = 2;
    localparam int QDEPTH    = 64;

    logic clk = 1'b0;
    logic rst;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BURST_MAX(BURST_MAX), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] sbuf [NUM_REQ][QDEPTH];
    int         shead [NUM_REQ];
    int         stail [NUM_REQ];

    int   last_g;
    int   cnt;
    int   ser_d, ser_l, ser_wait, ser_len;
    logic ser_busy;

    logic       prev_rdy;
    logic [7:0] prev_byte;
    logic       prev_ga;
    logic       start_seen;
    int         pop_r;
    int         ga_fall;
    int         vcyc;

    logic [7:0] tx_log [$];
    int         start_cyc [$];
    int         rdy_who [$];
    int         rdy_cyc [$];
    logic [7:0] exp_bytes [$];

    task automatic chk_eq(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pending(input int i);
        return stail[i] - shead[i];
    endfunction

    function automatic logic any_pending();
        logic a;
        a = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) a = a | (pending(i) > 0);
        return a;
    endfunction

    // Who must be served next: continue the burst if allowed, else first waiting source after last_g.
    function automatic int next_req();
        int i;
        if (cnt > 0 && cnt < BURST_MAX && pending(last_g) > 0) return last_g;
        for (int k = 1; k <= NUM_REQ; k++) begin
            i = (last_g + k) % NUM_REQ;
            if (pending(i) > 0) return i;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]      = (pending(i) > 0);
            bus.req_data[8*i +: 8] = (pending(i) > 0) ? sbuf[i][shead[i]] : 8'h00;
        end
        bus.tx_busy = ser_busy;
    endtask

    task automatic push(input int i, input logic [7:0] b);
        sbuf[i][stail[i]] = b;
        stail[i]++;
    endtask

    task automatic model_reset();
        last_g   = NUM_REQ - 1;
        cnt      = 0;
        ser_wait = 0;
        ser_len  = 0;
        ser_busy = 1'b0;
        prev_rdy = 1'b0;
        prev_ga  = 1'b0;
        pop_r    = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            shead[i] = 0;
            stail[i] = 0;
        end
    endtask

    task automatic clear_logs();
        tx_log.delete();
        start_cyc.delete();
        rdy_who.delete();
        rdy_cyc.delete();
        ga_fall = -1;
    endtask

    // One clock: check outputs at the falling edge, update sources and serializer after the rising edge.
    task automatic step();
        logic [NUM_REQ-1:0] rdy;
        int r, er;
        @(negedge clk);
        cyc++;
        rdy        = bus.req_ready;
        start_seen = 1'b0;
        pop_r      = -1;
        if (rst) begin
            chk_eq("rdy_in_rst", int'(rdy), 0);
        end else begin
            if (rdy != '0) begin
                chk_eq("rdy_onehot", $countones(rdy), 1);
                r = 0;
                for (int i = 0; i < NUM_REQ; i++) if (rdy[i]) r = i;
                er = next_req();
                chk_eq("rdy_who", r, er);
                chk_eq("rdy_grant_id", int'(bus.grant_id), r);
                chk_eq("rdy_grant_active", int'(bus.grant_active), 1);
                if (pending(r) > 0) begin
                    if (cnt > 0 && cnt < BURST_MAX && r == last_g) cnt++;
                    else begin
                        last_g = r;
                        cnt    = 1;
                    end
                    pop_r = r;
                end else begin
                    chk_eq("rdy_without_valid", pending(r), 1);
                end
                rdy_who.push_back(r);
                rdy_cyc.push_back(cyc);
            end
            if (prev_rdy) chk_eq("start_after_rdy", int'(bus.tx_start), 1);
            if (bus.tx_start) begin
                chk_eq("start_ser_idle", int'(ser_busy || ser_wait > 0), 0);
                chk_eq("start_grant_active", int'(bus.grant_active), 1);
                if (prev_rdy) begin
                    chk_eq("tx_byte", int'(bus.tx_byte), int'(prev_byte));
                end else begin
`ifdef UART_ARB_TAG_EN
                    er = next_req();
                    chk_eq("tag_byte", int'(bus.tx_byte), int'(8'hA0 | er[7:0]));
                    chk_eq("tag_grant_id", int'(bus.grant_id), er);
`else
                    chk_eq("start_without_rdy", int'(prev_rdy), 1);
`endif
                end
                start_seen = 1'b1;
                tx_log.push_back(bus.tx_byte);
                start_cyc.push_back(cyc);
            end
            if (prev_ga && !bus.grant_active) ga_fall = cyc;
        end
        prev_rdy = (rdy != '0) && !rst;
        if (pop_r >= 0) prev_byte = sbuf[pop_r][shead[pop_r]];
        prev_ga = bus.grant_active;
        @(posedge clk);
        #1;
        if (pop_r >= 0) shead[pop_r]++;
        if (ser_busy) begin
            ser_len--;
            if (ser_len == 0) ser_busy = 1'b0;
        end else if (ser_wait > 0) begin
            ser_wait--;
            if (ser_wait == 0) begin
                ser_busy = 1'b1;
                ser_len  = ser_l;
            end
        end
        if (start_seen) begin
            ser_wait = ser_d - 1;
            if (ser_wait == 0) begin
                ser_busy = 1'b1;
                ser_len  = ser_l;
            end
        end
        drive_inputs();
    endtask

    task automatic run_until_drained(input int budget, input string name);
        int n;
        n = 0;
        while ((any_pending() || ser_busy || ser_wait > 0 || prev_rdy) && n < budget) begin
            step();
            n++;
        end
        chk_eq({name, "_drained"}, int'(n < budget), 1);
        repeat (3) step();
        chk_eq({name, "_idle"}, int'(bus.grant_active), 0);
        cnt = 0;
    endtask

    task automatic chk_tx(input string name);
        chk_eq({name, "_len"}, tx_log.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < tx_log.size(); i++)
            chk_eq($sformatf("%s_b%0d", name, i), int'(tx_log[i]), int'(exp_bytes[i]));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pushed;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_busy   = 1'b0;
        ser_d         = 1;
        ser_l         = 10;
        model_reset();
        clear_logs();
        step();
        step();
        rst = 1'b0;
        chk_eq("rst_req_ready", int'(bus.req_ready), 0);
        chk_eq("rst_tx_start", int'(bus.tx_start), 0);
        chk_eq("rst_tx_byte", int'(bus.tx_byte), 0);
        chk_eq("rst_grant_id", int'(bus.grant_id), 0);
        chk_eq("rst_grant_active", int'(bus.grant_active), 0);

        // All four valid from reset, one byte each: round-robin order 0..3
        ser_d = 2; ser_l = 3;
        clear_logs();
        push(0, 8'hC0); push(1, 8'hC1); push(2, 8'hC2); push(3, 8'hC3);
        drive_inputs();
        run_until_drained(400, "all4");
        chk_eq("all4_nrdy", rdy_who.size(), 4);
        for (int i = 0; i < 4 && i < rdy_who.size(); i++) chk_eq($sformatf("all4_order%0d", i), rdy_who[i], i);
`ifdef UART_ARB_TAG_EN
        exp_bytes = '{8'hA0, 8'hC0, 8'hA1, 8'hC1, 8'hA2, 8'hC2, 8'hA3, 8'hC3};
`else
        exp_bytes = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
`endif
        chk_tx("all4");

        // Single byte from requester 0, serializer busy 10 cycles right after start
        ser_d = 1; ser_l = 10;
        clear_logs();
        push(0, 8'h5A);
        drive_inputs();
        vcyc = cyc + 1;
        run_until_drained(400, "single");
        chk_eq("single_nrdy", rdy_cyc.size(), 1);
        if (rdy_cyc.size() > 0) begin
`ifdef UART_ARB_TAG_EN
            chk_eq("single_rdy_lat", rdy_cyc[0] - vcyc, 14);
`else
            chk_eq("single_rdy_lat", rdy_cyc[0] - vcyc, 1);
`endif
        end
        if (start_cyc.size() > 0) begin
            chk_eq("single_start_lat", start_cyc[0] - vcyc, 2);
            chk_eq("single_idle_lat", ga_fall - start_cyc[start_cyc.size()-1], 12);
        end
`ifdef UART_ARB_TAG_EN
        exp_bytes = '{8'hA0, 8'h5A};
`else
        exp_bytes = '{8'h5A};
`endif
        chk_tx("single");

        // Burst limit: req 2 with six bytes competes with req 3
        ser_d = 2; ser_l = 3;
        clear_logs();
        for (int b = 1; b <= 6; b++) push(2, 8'(b));
        push(3, 8'h33);
        drive_inputs();
        run_until_drained(800, "burst");
`ifdef UART_ARB_TAG_EN
        exp_bytes = '{8'hA2, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA3, 8'h33, 8'hA2, 8'h05, 8'h06};
`else
        exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h33, 8'h05, 8'h06};
`endif
        chk_tx("burst");

        // Slow busy acknowledge: second start only after busy rose and fell
        ser_d = 5; ser_l = 10;
        clear_logs();
        push(1, 8'h51); push(1, 8'h52);
        drive_inputs();
        run_until_drained(400, "slowack");
        if (start_cyc.size() >= 2)
            chk_eq("slowack_gap", start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2], 17);
        else
            chk_eq("slowack_nstart", start_cyc.size(), 2);

        // Reset in the middle of a burst
        ser_d = 2; ser_l = 6;
        clear_logs();
        for (int b = 0; b < 6; b++) push(2, 8'h71 + 8'(b));
        drive_inputs();
        n = 0;
        while (!(rdy_who.size() >= 2 && ser_busy) && n < 300) begin
            step();
            n++;
        end
        chk_eq("midrst_reached", int'(n < 300), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        drive_inputs();
        chk_eq("midrst_req_ready", int'(bus.req_ready), 0);
        chk_eq("midrst_tx_start", int'(bus.tx_start), 0);
        chk_eq("midrst_tx_byte", int'(bus.tx_byte), 0);
        chk_eq("midrst_grant_id", int'(bus.grant_id), 0);
        chk_eq("midrst_grant_active", int'(bus.grant_active), 0);
        clear_logs();
        push(0, 8'h80); push(1, 8'h81);
        drive_inputs();
        run_until_drained(400, "postrst");
        chk_eq("postrst_nrdy", rdy_who.size(), 2);
        if (rdy_who.size() >= 2) begin
            chk_eq("postrst_first", rdy_who[0], 0);
            chk_eq("postrst_second", rdy_who[1], 1);
        end

        // Two-byte grant from requester 1
        ser_d = 1; ser_l = 4;
        clear_logs();
        push(1, 8'h11); push(1, 8'h22);
        drive_inputs();
        run_until_drained(400, "two");
        chk_eq("two_nrdy", rdy_who.size(), 2);
        for (int i = 0; i < rdy_who.size(); i++) chk_eq($sformatf("two_who%0d", i), rdy_who[i], 1);
`ifdef UART_ARB_TAG_EN
        exp_bytes = '{8'hA1, 8'h11, 8'h22};
`else
        exp_bytes = '{8'h11, 8'h22};
`endif
        chk_tx("two");

        // Randomized rounds of mixed sources and serializer timing
        for (int rd = 0; rd < 40; rd++) begin
            ser_d  = int'($urandom_range(1, 4));
            ser_l  = int'($urandom_range(1, 8));
            pushed = 0;
            clear_logs();
            for (int i = 0; i < NUM_REQ; i++) begin
                shead[i] = 0;
                stail[i] = 0;
                if ($urandom_range(0, 1) == 1) begin
                    n = int'($urandom_range(1, 6));
                    for (int b = 0; b < n; b++) push(i, 8'($urandom));
                    pushed += n;
                end
            end
            drive_inputs();
            run_until_drained(2000, "rand");
            chk_eq("rand_count", rdy_who.size(), pushed);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
